// File: rtl/ppu_ctrl_pkg.sv
// Shared definitions for the PPU control register block: register map,
// STATUS bit layout, reset constants used by both this block and the PPU
// double buffer, the commit FSM state type and byte-lane write merging.
package ppu_ctrl_pkg;

  typedef enum logic [2:0] {
    ADDR_BGSCROLL = 3'd0,
    ADDR_FGSCROLL = 3'd1,
    ADDR_ENABLE   = 3'd2,
    ADDR_BGCOLOR  = 3'd3,
    ADDR_STATUS   = 3'd4,
    ADDR_COMMIT   = 3'd5,
    ADDR_IRQEN    = 3'd6,
    ADDR_RSVD     = 3'd7
  } regAddr_e;

  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_APPLIED_BIT = 1;
  localparam int STATUS_COUNT_LSB   = 16;

  localparam logic [31:0] BGSCROLL_RST = 32'h0001_0000;
  localparam logic [31:0] FGSCROLL_RST = 32'h0000_0000;
  localparam logic [2:0]  ENABLE_RST   = 3'b111;
  localparam logic [23:0] BGCOLOR_RST  = 24'h00_0000;

  // Implemented-bit masks; shadow registers keep unimplemented bits at zero
  localparam logic [31:0] ENABLE_MASK  = 32'h0000_0007;
  localparam logic [31:0] BGCOLOR_MASK = 32'h00FF_FFFF;
  localparam logic [31:0] IRQEN_MASK   = 32'h0000_0001;

  typedef enum logic {
    COMMIT_IDLE    = 1'b0,
    COMMIT_PENDING = 1'b1
  } commitState_e;

  // Replace the byte lanes selected by byteEn, then drop unimplemented bits
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  byteEn,
                                             input logic [31:0] implMask);
    logic [31:0] result;
    result = oldVal;
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) result[8*i +: 8] = newVal[8*i +: 8];
    end
    return result & implMask;
  endfunction

endpackage

// File: rtl/ppu_ctrl_csr.sv
// Avalon-MM register block that stages PPU scroll/enable/colour settings in
// shadow registers and publishes them atomically on a COMMIT write. Tracks
// the commit until the next frame sync and counts frames.
module ppu_ctrl_csr
  import ppu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              irq,
  output logic [31:0]       ppu_bgscroll,
  output logic [31:0]       ppu_fgscroll,
  output logic [2:0]        ppu_enable,
  output logic [23:0]       ppu_bgcolor
);

  commitState_e r_state;
  commitState_e w_nextState;
  logic         w_applyNow;

  logic [31:0] r_shBg;
  logic [31:0] r_shFg;
  logic [31:0] r_shEn;
  logic [31:0] r_shColor;
  logic [31:0] r_irqEn;

  logic [31:0] r_ppuBg;
  logic [31:0] r_ppuFg;
  logic [2:0]  r_ppuEn;
  logic [23:0] r_ppuColor;

  logic        r_frameApplied;
  logic [15:0] r_frameCount;
  logic        r_irq;
  logic [31:0] r_readData;
  logic        r_readValid;

  regAddr_e    w_addr;
  logic        w_commit;
  logic        w_w1c;
  logic        w_pending;
  logic [31:0] w_status;
  logic [31:0] w_readMux;

  assign w_addr    = regAddr_e'(avs_address[2:0]);
  assign w_commit  = avs_write && (w_addr == ADDR_COMMIT);
  assign w_w1c     = avs_write && (w_addr == ADDR_STATUS) && avs_byteenable[0]
                     && avs_writedata[STATUS_APPLIED_BIT];
  assign w_pending = (r_state == COMMIT_PENDING);
  assign w_status  = {r_frameCount, 14'd0, r_frameApplied, w_pending};

  // Commit FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= COMMIT_IDLE;
    else     r_state <= w_nextState;
  end

  // Commit FSM next state; a commit coinciding with sync keeps us pending
  always_comb begin
    w_nextState = r_state;
    w_applyNow  = 1'b0;
    case (r_state)
      COMMIT_IDLE: begin
        if (w_commit) w_nextState = COMMIT_PENDING;
      end
      COMMIT_PENDING: begin
        if (w_commit) begin
          w_nextState = COMMIT_PENDING;
        end else if (sync) begin
          w_nextState = COMMIT_IDLE;
          w_applyNow  = 1'b1;
        end
      end
      default: w_nextState = COMMIT_IDLE;
    endcase
  end

  // Shadow registers written by the CPU through byte lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shBg    <= BGSCROLL_RST;
      r_shFg    <= FGSCROLL_RST;
      r_shEn    <= {29'd0, ENABLE_RST};
      r_shColor <= {8'd0, BGCOLOR_RST};
      r_irqEn   <= 32'd0;
    end else if (avs_write) begin
      case (w_addr)
        ADDR_BGSCROLL: r_shBg    <= mergeBytes(r_shBg, avs_writedata, avs_byteenable, 32'hFFFF_FFFF);
        ADDR_FGSCROLL: r_shFg    <= mergeBytes(r_shFg, avs_writedata, avs_byteenable, 32'hFFFF_FFFF);
        ADDR_ENABLE:   r_shEn    <= mergeBytes(r_shEn, avs_writedata, avs_byteenable, ENABLE_MASK);
        ADDR_BGCOLOR:  r_shColor <= mergeBytes(r_shColor, avs_writedata, avs_byteenable, BGCOLOR_MASK);
        ADDR_IRQEN:    r_irqEn   <= mergeBytes(r_irqEn, avs_writedata, avs_byteenable, IRQEN_MASK);
        default: ;
      endcase
    end
  end

  // Committed outputs reload together so the PPU never sees a mixed set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ppuBg    <= BGSCROLL_RST;
      r_ppuFg    <= FGSCROLL_RST;
      r_ppuEn    <= ENABLE_RST;
      r_ppuColor <= BGCOLOR_RST;
    end else if (w_commit) begin
      r_ppuBg    <= r_shBg;
      r_ppuFg    <= r_shFg;
      r_ppuEn    <= r_shEn[2:0];
      r_ppuColor <= r_shColor[23:0];
    end
  end

  // Frame-applied flag (set beats clear), frame counter and registered irq
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frameApplied <= 1'b0;
      r_frameCount   <= 16'd0;
      r_irq          <= 1'b0;
    end else begin
      if (w_applyNow)  r_frameApplied <= 1'b1;
      else if (w_w1c)  r_frameApplied <= 1'b0;
      if (sync)        r_frameCount   <= r_frameCount + 16'd1;
      r_irq <= r_frameApplied & r_irqEn[0];
    end
  end

  // Read mux over pre-write register values
  always_comb begin
    w_readMux = 32'd0;
    case (w_addr)
      ADDR_BGSCROLL: w_readMux = r_shBg;
      ADDR_FGSCROLL: w_readMux = r_shFg;
      ADDR_ENABLE:   w_readMux = r_shEn;
      ADDR_BGCOLOR:  w_readMux = r_shColor;
      ADDR_STATUS:   w_readMux = w_status;
      ADDR_IRQEN:    w_readMux = r_irqEn;
      default:       w_readMux = 32'd0;
    endcase
  end

  // Fixed one-cycle read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_readData  <= 32'd0;
      r_readValid <= 1'b0;
    end else begin
      r_readValid <= avs_read;
      if (avs_read) r_readData <= w_readMux;
    end
  end

  assign avs_readdata      = r_readData;
  assign avs_readdatavalid = r_readValid;
  assign irq               = r_irq;
  assign ppu_bgscroll      = r_ppuBg;
  assign ppu_fgscroll      = r_ppuFg;
  assign ppu_enable        = r_ppuEn;
  assign ppu_bgcolor       = r_ppuColor;

endmodule

// File: doc/ppu_ctrl_csr.md
# ppu_ctrl_csr

CPU-facing writer for the PPU control registers: an Avalon-MM slave through which the HPS writes background/foreground scroll, layer enable and background colour into shadow registers. A COMMIT write copies all shadow registers into the `ppu_*` outputs in one cycle. The PPU's sync-latched double buffer consumes those outputs, so software never produces a torn frame. The block tracks the commit until the next frame sync, keeps a frame counter, and raises an optional frame-applied interrupt.

## Interface
- `ADDR_W`, 3, word-address width of the slave
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  reset, synchronous and active-high
- `sync`  in  1  single-cycle frame-boundary pulse, the same pulse the PPU double buffer latches on
- `avs_address`  in  ADDR_W  word address
- `avs_read`  in  1  read strobe
- `avs_write`  in  1  write strobe
- `avs_writedata`  in  32  write data
- `avs_byteenable`  in  4  byte lanes for the write
- `avs_readdata`  out  32  read data, registered
- `avs_readdatavalid`  out  1  high for one cycle, one cycle after `avs_read`
- `irq`  out  1  level interrupt to HPS
- `ppu_bgscroll`  out  32  committed background scroll
- `ppu_fgscroll`  out  32  committed foreground scroll
- `ppu_enable`  out  3  committed layer enables
- `ppu_bgcolor`  out  24  committed background colour (RGB888)

## Operation
- Register map (word addresses):
  - 0 BGSCROLL, RW32.
  - 1 FGSCROLL, RW32.
  - 2 ENABLE, RW [2:0].
  - 3 BGCOLOR, RW [23:0].
  - 4 STATUS, RO except bit1: [0] commit_pending, [1] frame_applied (write 1 to clear), [31:16] frame_count.
  - 5 COMMIT, WO; any write commits.
  - 6 IRQEN, RW [0].
  - 7 reads 0; writes are ignored.
- Writes to 0–3 and 6 update shadow registers per byteenable. Unimplemented bits read 0.
- Reads of 0–3 return shadow values, not committed values.
- COMMIT write copies every shadow register into its `ppu_*` output in the same edge and sets commit_pending.
- The next `sync` pulse after a commit clears commit_pending and sets frame_applied.
- frame_count increments on every `sync` pulse, 16-bit, and wraps from FFFF to 0000.
- `irq` = frame_applied & IRQEN[0], registered.
- Commit FSM:
  - IDLE, on COMMIT write -> PENDING.
  - PENDING, on `sync` -> IDLE, setting frame_applied.
  - PENDING, on COMMIT write without `sync` -> stays PENDING; `ppu_*` reloaded from shadow.
- Shadow writes during PENDING are allowed and do not affect `ppu_*`.

## Timing
- Reset values:
  - Shadow and `ppu_bgscroll` = 32'h0001_0000; `ppu_fgscroll` = 0; `ppu_enable` = 3'b111; `ppu_bgcolor` = 0.
  - STATUS = 0, IRQEN = 0, FSM = IDLE.
  - `avs_readdata` = 0, `avs_readdatavalid` = 0, `irq` = 0.
- Write takes effect at the edge where `avs_write` is sampled. The slave has no waitrequest.
- Fixed read latency of 1: data and valid are registered from the sampled address. `avs_read` and `avs_write` asserted together: the write applies and the read returns pre-write data.
- `ppu_*` change only on a COMMIT edge, all four in the same cycle. Downstream therefore samples either all-old or all-new values.
- COMMIT in the same cycle as `sync`:
  - `ppu_*` load new values.
  - Downstream latches the old values on that pulse.
  - FSM enters/stays PENDING and does not clear; frame_applied is not set.
  - The following `sync` applies the new values and clears pending.
- W1C of frame_applied in the same cycle it is set: set wins.
- `irq` follows frame_applied/IRQEN changes one cycle later.
- `rst` mid-PENDING: FSM returns to IDLE and outputs return to reset values in that cycle.

## Structure
- `ppu_ctrl_pkg` holds:
  - register address enum;
  - STATUS bit positions;
  - reset constants for scroll, enable and colour, shared with the PPU double buffer so both ends reset identically;
  - commit FSM state typedef.
- No sub-module is needed. Byte-lane write merging is a function in the package.

## Test plan
- Reset, then read addresses 0–6 -> 0x00010000, 0, 0x7, 0, 0, 0, 0; `ppu_*` at reset constants.
- Write BGSCROLL=0x12345678 with byteenable=4'b0011, read back -> 0x00015678; `ppu_bgscroll` unchanged until COMMIT, then 0x00015678 next cycle.
- COMMIT, then `sync` 5 cycles later -> STATUS[0]=1 until the sync edge; after it, STATUS[0]=0, STATUS[1]=1, frame_count=1. With IRQEN=1, `irq` rises one cycle after frame_applied; writing STATUS=0x2 drops it.
- COMMIT coincident with `sync` -> pending stays 1, frame_applied stays 0; the next `sync` clears pending and sets frame_applied.
- 65536 `sync` pulses -> frame_count wraps to 0. W1C coincident with a set event -> frame_applied remains 1.
- `rst` asserted while PENDING with committed BGCOLOR=0xFF00FF -> next cycle `ppu_bgcolor`=0, STATUS=0, `irq`=0.
